// File: rtl/drive_pkg.sv
// Shared types for the manual driving controller: FSM states and motor direction codes.
package drive_pkg;

    typedef enum logic [2:0] {
        IDLE,
        NEUTRAL,
        CLUTCH,
        DRIVE,
        REVERSE,
        STALL
    } state_t;

    localparam logic [1:0] DRV_STOP = 2'b00;
    localparam logic [1:0] DRV_FWD  = 2'b01;
    localparam logic [1:0] DRV_REV  = 2'b10;

endpackage

// File: rtl/turn_blinker.sv
// Turn/hazard indicator blinker: free-running half-period counter, phase flop and
// lamp masking, cleared whenever no lamp is requested or the blinker is disabled.
module turn_blinker #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic turn_left,
    input  logic turn_right,
    output logic lamp_l,
    output logic lamp_r
);

    localparam int CW = $clog2(BLINK_DIV);

    logic [CW-1:0] cnt;
    logic          phase;
    logic [1:0]    mask;

    assign mask = {turn_right, turn_left};

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            phase  <= 1'b1;
            lamp_l <= 1'b0;
            lamp_r <= 1'b0;
        end else if (!en || mask == 2'b00) begin
            cnt    <= '0;
            phase  <= 1'b1;
            lamp_l <= 1'b0;
            lamp_r <= 1'b0;
        end else begin
            // Lamps take the phase held before this edge, so a fresh request lights at once.
            lamp_l <= mask[0] & phase;
            lamp_r <= mask[1] & phase;
            if (cnt == CW'(BLINK_DIV - 1)) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/manual_drive_ctrl.sv
// Manual-transmission driving controller: clutch/gear FSM, shift edge detection,
// registered drive outputs, indicator lamps and a saturating odometer.
module manual_drive_ctrl
    import drive_pkg::*;
#(
    parameter int NUM_GEARS = 3,
    parameter int GW        = $clog2(NUM_GEARS + 1),
    parameter int BLINK_DIV = 25_000_000,
    parameter int MILE_DIV  = 50_000_000,
    parameter int MILE_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              throttle,
    input  logic              clutch,
    input  logic              brake,
    input  logic              rev_gear,
    input  logic              shift_up,
    input  logic              shift_down,
    input  logic              turn_left,
    input  logic              turn_right,
    output logic              power,
    output logic [1:0]        drive,
    output logic [1:0]        steer,
    output logic [GW-1:0]     gear,
    output logic [GW-1:0]     speed,
    output logic              lamp_l,
    output logic              lamp_r,
    output logic [MILE_W-1:0] mileage
);

    localparam int MCW = $clog2(MILE_DIV);
    localparam int SW  = MILE_W + 1;

    state_t            state_q, state_d;
    logic [GW-1:0]     gear_d;
    logic              su_q, sd_q, su_edge, sd_edge;
    logic              power_d;
    logic [1:0]        drive_d, steer_d;
    logic [GW-1:0]     speed_d;
    logic              blink_en;
    logic [MCW-1:0]    mcnt_q, mcnt_d;
    logic [MILE_W-1:0] mileage_d;
    logic [SW-1:0]     mile_sum;

    assign su_edge = shift_up & ~su_q;
    assign sd_edge = shift_down & ~sd_q;

    // NOTE: every variable gets a default before any branch; a path that leaves one
    // unassigned would infer a latch instead of combinational logic.
    always_comb begin
        state_d = state_q;
        gear_d  = gear;
        if (!en) begin
            state_d = IDLE;
            gear_d  = '0;
        end else begin
            unique case (state_q)
                IDLE:    state_d = NEUTRAL;
                NEUTRAL: begin
                    if (clutch)        state_d = CLUTCH;
                    else if (brake)    state_d = NEUTRAL;
                    else if (throttle) state_d = STALL;
                end
                CLUTCH: begin
                    if (su_edge && !sd_edge && gear < GW'(NUM_GEARS))
                        gear_d = gear + GW'(1);
                    else if (sd_edge && !su_edge && gear != '0)
                        gear_d = gear - GW'(1);
                    if (!clutch) begin
                        if (rev_gear)          state_d = REVERSE;
                        else if (gear_d == '0) state_d = NEUTRAL;
                        else                   state_d = DRIVE;
                    end
                end
                DRIVE: begin
                    if (clutch)        state_d = CLUTCH;
                    else if (rev_gear) state_d = STALL;
                    else if (brake) begin
                        state_d = NEUTRAL;
                        gear_d  = '0;
                    end
                end
                REVERSE: begin
                    if (clutch)         state_d = CLUTCH;
                    else if (!rev_gear) state_d = STALL;
                    else if (brake) begin
                        state_d = NEUTRAL;
                        gear_d  = '0;
                    end
                end
                STALL:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        if (state_d == STALL)
            gear_d = '0;
    end

    // Registered outputs are derived from the next state and the inputs of this cycle.
    always_comb begin
        drive_d = DRV_STOP;
        if (state_d == DRIVE && throttle)
            drive_d = DRV_FWD;
        else if (state_d == REVERSE && throttle)
            drive_d = DRV_REV;
        speed_d = '0;
        if (drive_d == DRV_FWD)
            speed_d = gear_d;
        else if (drive_d == DRV_REV)
            speed_d = GW'(1);
        steer_d  = (drive_d != DRV_STOP) ? {turn_right, turn_left} : 2'b00;
        power_d  = (state_d != STALL);
        blink_en = (state_d != IDLE) && (state_d != STALL);
    end

    always_comb begin
        mcnt_d    = mcnt_q;
        mileage_d = mileage;
        mile_sum  = {1'b0, mileage} + SW'(speed_d);
        if (!en) begin
            mcnt_d = '0;
        end else if (drive_d != DRV_STOP) begin
            if (mcnt_q == MCW'(MILE_DIV - 1)) begin
                mcnt_d    = '0;
                mileage_d = mile_sum[MILE_W] ? '1 : mile_sum[MILE_W-1:0];
            end else begin
                mcnt_d = mcnt_q + MCW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gear    <= '0;
            su_q    <= 1'b0;
            sd_q    <= 1'b0;
            power   <= 1'b1;
            drive   <= DRV_STOP;
            steer   <= 2'b00;
            speed   <= '0;
            mcnt_q  <= '0;
            mileage <= '0;
        end else begin
            state_q <= state_d;
            gear    <= gear_d;
            su_q    <= shift_up;
            sd_q    <= shift_down;
            power   <= power_d;
            drive   <= drive_d;
            steer   <= steer_d;
            speed   <= speed_d;
            mcnt_q  <= mcnt_d;
            mileage <= mileage_d;
        end
    end

    turn_blinker #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blinker (
        .clk        (clk),
        .rst        (rst),
        .en         (blink_en),
        .turn_left  (turn_left),
        .turn_right (turn_right),
        .lamp_l     (lamp_l),
        .lamp_r     (lamp_r)
    );

endmodule

// File: doc/manual_drive_ctrl.md
# manual_drive_ctrl

Parametrised manual-transmission driving controller for the car top level, active when the mode selector chooses manual driving. It decodes throttle, clutch, brake, reverse, shift and turn switches into a registered motor direction, a gear-derived speed level, steering, blinking indicator lamps and a saturating mileage count. Compared with the first-generation manual driver, it adds N selectable forward gears, hazard/turn lamp blinking and odometry.

## Interface
Parameters:
- NUM_GEARS, 3, number of forward gears (≥1); gear 0 = neutral
- GW, $clog2(NUM_GEARS+1), gear/speed width (derived, not overridden)
- BLINK_DIV, 25_000_000, lamp half-period in clk cycles (≥2)
- MILE_DIV, 50_000_000, moving cycles per mileage accumulation (≥2)
- MILE_W, 16, mileage counter width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  manual mode selected (mode==2'b01 decoded upstream)
- throttle, clutch, brake, rev_gear  in  1 each  driver switches
- shift_up, shift_down  in  1 each  gear switches, rising-edge detected internally
- turn_left, turn_right  in  1 each  turn requests
- power  out  1  0 for exactly one cycle on stall, else 1
- drive  out  2  01 forward, 10 reverse, 00 stop
- steer  out  2  {right,left} steering command
- gear  out  GW  selected gear
- speed  out  GW  speed level
- lamp_l, lamp_r  out  1 each  indicator lamps
- mileage  out  MILE_W  accumulated distance

## Operation
- Reset values: state IDLE, power=1, drive=00, steer=00, gear=0, speed=0, lamps=0, mileage=0, blink and mile counters 0.
- en low (synchronous): same values as reset except mileage, which holds.
- Each state is listed with its transitions in priority order:
  - IDLE: go to NEUTRAL unconditionally.
  - NEUTRAL: clutch → CLUTCH; brake → stay; throttle → STALL.
  - CLUTCH: on a shift_up edge, gear = min(gear+1, NUM_GEARS); on a shift_down edge, gear = max(gear−1, 0); both edges in the same cycle → no change. When clutch is released: rev_gear → REVERSE; gear==0 → NEUTRAL; else → DRIVE.
  - DRIVE: clutch → CLUTCH; rev_gear → STALL; brake → NEUTRAL with gear cleared to 0; otherwise stay, with drive=01 while throttle is high.
  - REVERSE: clutch → CLUTCH; !rev_gear → STALL; brake → NEUTRAL with gear cleared to 0; otherwise stay, with drive=10 while throttle is high.
  - STALL: power=0 and gear=0 for this single cycle, then → IDLE.
- Shift edges outside CLUTCH are ignored. The shift edge detectors still update every cycle.
- speed = gear when drive=01; speed = 1 when drive=10; otherwise 0.
- steer = {turn_right, turn_left} when drive≠00, else 00.
- Lamps operate in every state except IDLE and STALL:
  - Request mask = {turn_right, turn_left}. Both bits set means hazard: both lamps blink in phase.
  - With a non-zero mask, the blink counter runs and the phase toggles each BLINK_DIV cycles. Lamps = mask & phase.
  - With a zero mask, the counter clears to 0 and phase resets to 1.
- Mileage:
  - The mile counter advances only while drive≠00, and holds otherwise.
  - When the count reaches MILE_DIV−1 it wraps to 0 and mileage += speed.
  - mileage saturates at all-ones.

## Timing
- All outputs are registered.
- Inputs are sampled at edge k. The state and every output reflecting them appear after edge k (one-cycle latency). Outputs are computed from the next state and the current inputs.
- Lamps turn on the cycle after a request appears. They go off after BLINK_DIV cycles and alternate every BLINK_DIV cycles thereafter.
- power is low for exactly one cycle. drive is 00 during that cycle.
- Asserting rst mid-operation forces the reset values immediately, independent of clk. Deassertion takes effect at the next clk edge.
- Dropping en in any state reaches IDLE at the next edge. No STALL pulse is produced.

## Structure
- Package drive_pkg holds:
  - the state enum (IDLE, NEUTRAL, CLUTCH, DRIVE, REVERSE, STALL);
  - the drive encodings DRV_STOP, DRV_FWD, DRV_REV.
- Sub-module turn_blinker(BLINK_DIV) holds the blink counter, phase flop and lamp masking.
- The FSM, gear register, edge detectors and odometer stay in manual_drive_ctrl.

## Test plan
All scenarios use NUM_GEARS=3, BLINK_DIV=4, MILE_DIV=8.
- Reset, then en=1, then throttle=1 → IDLE, NEUTRAL, STALL; power=0 for one cycle; back to IDLE.
- Hold clutch and pulse shift_up 4 times → gear 1,2,3,3. Release clutch, throttle=1 → drive=01, speed=3. Brake → NEUTRAL, gear=0, drive=00.
- In CLUTCH, pulse shift_up and shift_down in the same cycle → gear unchanged. Release with rev_gear=1, throttle=1 → drive=10, speed=1. Drop rev_gear → one power=0 cycle.
- Hold turn_left → lamp_l pattern 1111 0000 1111, lamp_r=0. Hold both → lamps identical. Release → lamps=0 the next cycle.
- Drive in gear 2 for 24 moving cycles → mileage=6. Stop and lower en → mileage holds at 6. Pulse rst → 0.
- Preload mileage near all-ones (MILE_W=4), drive gear 3 → saturates at 15. Assert rst asynchronously mid-drive → all outputs go to reset values before the next clk edge.
